lector_colas: RTL and testbench
===============================

LECTOR_COLAS -- requirements
Module: lector_colas

Interface
REQ-001 Parameter QUEUE_QUANTITY, default 4, number of source FIFOs.
REQ-002 Parameter DATA_BITS, default 8, FIFO word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enb  input  1  block enable; low freezes the FSM.
REQ-006 selector  input  $clog2(QUEUE_QUANTITY)  queue index granted by the weighted round-robin arbiter.
REQ-007 selector_enb  input  1  grant valid qualifier for selector.
REQ-008 buf_empty  input  QUEUE_QUANTITY  per-FIFO empty flags, bit i = queue i.
REQ-009 buf_rd_data  input  QUEUE_QUANTITY*DATA_BITS  concatenated FIFO read ports; slice i = bits [i*DATA_BITS +: DATA_BITS].
REQ-010 pop  output  QUEUE_QUANTITY  registered one-hot FIFO read strobe.
REQ-011 out_data  output  DATA_BITS  registered word delivered downstream.
REQ-012 out_valid  output  1  out_data valid.
REQ-013 out_ready  input  1  downstream accepts out_data when high with out_valid.
REQ-014 contador  output  QUEUE_QUANTITY*16  per-queue delivered-word counters (see Configuration).

Function
REQ-015 FSM states: IDLE, POP, WAIT, HOLD; all transitions require enb=1 except HOLD exit.
REQ-016 IDLE: if selector_enb=1, selector<QUEUE_QUANTITY and buf_empty[selector]=0, latch sel_q<=selector, pop<=one-hot(selector), go POP; else stay IDLE, pop=0.
REQ-017 POP: pop high exactly this one cycle; next edge pop<=0, go WAIT.
REQ-018 WAIT: FIFO read data is valid (synchronous-read FIFO); next edge out_data<=slice sel_q of buf_rd_data, out_valid<=1, go HOLD.
REQ-019 HOLD: out_data, out_valid stable until out_ready=1 at a rising edge; then out_valid<=0, go IDLE.
REQ-020 Latency: grant sampled at edge N -> pop high cycle N..N+1 -> out_valid high from edge N+2; minimum 4 cycles per word with out_ready tied high.
REQ-021 Grants arriving outside IDLE are ignored, never queued.
REQ-022 Grant to an empty queue or out-of-range index: no pop, no state change.
REQ-023 pop never has more than one bit set; pop is never asserted outside POP.
REQ-024 enb=0: state, sel_q, out_data held; pop forced 0 on the next edge; HOLD still exits on out_ready (handshake never stalls downstream).
REQ-025 buf_empty changes after grant acceptance do not abort the transaction.

Reset
REQ-026 rst=1 immediately forces state=IDLE, pop=0, out_valid=0, out_data=0, sel_q=0, all contador fields=0, independent of clk.
REQ-027 Reset mid-transaction (POP/WAIT/HOLD) drops the in-flight word; no pop issued after rst deasserts until a new grant.

Configuration
REQ-028 Macro LECTOR_CONTADOR_EN: when defined, contador field i increments by 1 on each HOLD->IDLE transfer with sel_q=i, saturating at 16'hFFFF.
REQ-029 Without LECTOR_CONTADOR_EN: contador is constant 0 and no counter registers are synthesized; all other behaviour identical.

Verification
REQ-030 rst high 40 ns, buf_empty=4'b0000, selector=2, selector_enb=1, out_ready=1 -> pop=4'b0100 one cycle, out_data=slice 2 value two edges after pop, out_valid one cycle.
REQ-031 buf_empty=4'b0010, selector=1, selector_enb=1 for 10 cycles -> pop stays 0, out_valid stays 0.
REQ-032 Word 8'hA5 from queue 3, out_ready=0 for 5 cycles then 1 -> out_valid held 6 cycles with out_data=8'hA5 stable; selector changes meanwhile cause no pop.
REQ-033 rst pulsed asynchronously during WAIT -> pop, out_valid drop at once; no output word follows.
REQ-034 LECTOR_CONTADOR_EN defined, grant sequence 3,0,1,2,3 with out_ready=1 -> contador fields {q3,q2,q1,q0} = {2,1,1,1}; macro undefined -> all 0.
REQ-035 enb=0 for 3 cycles while in POP -> pop cleared after one cycle, state held; enb=1 resumes to WAIT and delivers the word.

Source files
------------

// File: rtl/lector_colas.sv
// lector_colas: reads one word at a time from the FIFO chosen by an external
// weighted round-robin arbiter and presents it downstream with a valid/ready
// handshake. The per-queue delivered-word counters exist only when the
// LECTOR_CONTADOR_EN macro is defined; otherwise contador_o is tied to zero.
module lector_colas #(
    parameter int unsigned QUEUE_QUANTITY = 4,
    parameter int unsigned DATA_BITS      = 8,
    localparam int unsigned SelBits = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                enb_i,
    input  logic [SelBits-1:0]                  selector_i,
    input  logic                                selector_enb_i,
    input  logic [QUEUE_QUANTITY-1:0]           buf_empty_i,
    input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] buf_rd_data_i,
    output logic [QUEUE_QUANTITY-1:0]           pop_o,
    output logic [DATA_BITS-1:0]                out_data_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic [QUEUE_QUANTITY*16-1:0]        contador_o
);

    typedef enum logic [1:0] {
        StIdle,
        StPop,
        StWait,
        StHold
    } state_e;

    state_e                      state_q;
    logic [SelBits-1:0]          sel_q;
    logic [QUEUE_QUANTITY-1:0]   pop_q;
    logic [DATA_BITS-1:0]        out_data_q;
    logic                        out_valid_q;

    logic                        grant_ok;
    logic [QUEUE_QUANTITY-1:0]   grant_onehot;
    logic [DATA_BITS-1:0]        rd_word;
    logic                        xfer_done;

    // Decode the grant against the empty flags and mux the latched queue's read port.
    // Out-of-range selector values match no queue, so they never produce a grant.
    always_comb begin
        grant_ok     = 1'b0;
        grant_onehot = '0;
        rd_word      = '0;
        for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
            if (selector_enb_i && (selector_i == SelBits'(i)) && !buf_empty_i[i]) begin
                grant_ok        = 1'b1;
                grant_onehot[i] = 1'b1;
            end
            if (sel_q == SelBits'(i)) begin
                rd_word = buf_rd_data_i[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign xfer_done = (state_q == StHold) && out_ready_i;

    // Read FSM with registered outputs; pop defaults low so it lasts a single cycle
    // and drops immediately whenever enb_i is low. HOLD exit ignores enb_i so the
    // downstream handshake never stalls.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            pop_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pop_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (enb_i && grant_ok) begin
                        sel_q   <= selector_i;
                        pop_q   <= grant_onehot;
                        state_q <= StPop;
                    end
                end
                StPop: begin
                    if (enb_i) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (enb_i) begin
                        out_data_q  <= rd_word;
                        out_valid_q <= 1'b1;
                        state_q     <= StHold;
                    end
                end
                StHold: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign pop_o       = pop_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

`ifdef LECTOR_CONTADOR_EN
    logic [QUEUE_QUANTITY-1:0][15:0] cnt_q;

    // Count words accepted downstream per source queue, saturating at all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (xfer_done) begin
            for (int unsigned i = 0; i < QUEUE_QUANTITY; i++) begin
                if ((sel_q == SelBits'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign contador_o = cnt_q;
`else
    logic unused_xfer_done;
    assign unused_xfer_done = xfer_done;
    assign contador_o       = '0;
`endif

endmodule

// File: tb/tb_lector_colas.sv
// Scoreboard bench for lector_colas: expected pop vectors and output words are
// queued as grants are issued; a negedge monitor checks them as the DUT shows them.
module tb_lector_colas;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enb = 1'b1;
    logic [1:0]  selector = 2'd0;
    logic        selector_enb = 1'b0;
    logic [3:0]  buf_empty = 4'b0000;
    logic [31:0] buf_rd_data = 32'hA533_2211;  // q3=A5 q2=33 q1=22 q0=11
    logic [3:0]  pop;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] contador;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;

    logic [3:0] exp_pop[$];
    logic [7:0] exp_data[$];
    logic [3:0] mon_ep;

    lector_colas #(
        .QUEUE_QUANTITY(4),
        .DATA_BITS     (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enb_i         (enb),
        .selector_i    (selector),
        .selector_enb_i(selector_enb),
        .buf_empty_i   (buf_empty),
        .buf_rd_data_i (buf_rd_data),
        .pop_o         (pop),
        .out_data_o    (out_data),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .contador_o    (contador)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a single-cycle grant; caller guarantees the FSM sits in IDLE.
    task automatic grant(input logic [1:0] q, input logic [3:0] p, input bit want_data,
                         input logic [7:0] d);
        selector     = q;
        selector_enb = 1'b1;
        exp_pop.push_back(p);
        if (want_data) exp_data.push_back(d);
        step();
        selector_enb = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_pop.size() != 0 || exp_data.size() != 0 || out_valid) && n < 30) begin
            step();
            n++;
        end
        chk("drain_pending", 64'(exp_pop.size() + exp_data.size()), 64'd0);
        exp_pop.delete();
        exp_data.delete();
    endtask

    // Monitor: every pop must match the next expected strobe, every valid word the
    // next expected word; a word retires only when out_ready accepts it.
    always @(negedge clk) begin
        if (!rst) begin
            if (pop != 4'b0000) begin
                if (exp_pop.size() == 0) begin
                    chk("pop_unexpected", 64'(pop), 64'd0);
                end else begin
                    mon_ep = exp_pop.pop_front();
                    chk("pop_vec", 64'(pop), 64'(mon_ep));
                end
            end
            if (out_valid) begin
                valid_cnt++;
                if (exp_data.size() == 0) begin
                    chk("valid_unexpected", 64'(out_valid), 64'd0);
                end else begin
                    chk("out_data", 64'(out_data), 64'(exp_data[0]));
                    if (out_ready) void'(exp_data.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int v0;
        logic [1:0] seq[5];
        logic [7:0] seq_d[5];
        logic [63:0] exp_cnt;

        // Reset state
        #20;
        chk("rst_pop", 64'(pop), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_contador", contador, 64'd0);
        #20 rst = 1'b0;
        step();

        // Basic read from queue 2 with latency checks
        grant(2'd2, 4'b0100, 1'b1, 8'h33);
        @(negedge clk);
        chk("t1_pop_onehot", 64'(pop), 64'h4);
        chk("t1_pop_valid", 64'(out_valid), 64'd0);
        step();
        @(negedge clk);
        chk("t1_wait_pop", 64'(pop), 64'd0);
        chk("t1_wait_valid", 64'(out_valid), 64'd0);
        step();
        @(negedge clk);
        chk("t1_hold_valid", 64'(out_valid), 64'd1);
        chk("t1_hold_data", 64'(out_data), 64'h33);
        step();
        @(negedge clk);
        chk("t1_done_valid", 64'(out_valid), 64'd0);
        drain();

        // Grant to an empty queue is ignored
        buf_empty    = 4'b0010;
        selector     = 2'd1;
        selector_enb = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (pop != 4'b0000 || out_valid) bad++;
        end
        chk("empty_q_ignored", 64'(bad), 64'd0);
        selector_enb = 1'b0;
        buf_empty    = 4'b0000;
        step();

        // Backpressure: A5 from queue 3 held 6 cycles, grants meanwhile ignored
        out_ready = 1'b0;
        v0 = valid_cnt;
        grant(2'd3, 4'b1000, 1'b1, 8'hA5);
        selector     = 2'd0;
        selector_enb = 1'b1;
        step();
        step();
        repeat (5) step();
        selector_enb = 1'b0;
        out_ready    = 1'b1;
        step();
        step();
        chk("hold_valid_cycles", 64'(valid_cnt - v0), 64'd6);
        drain();

        // Asynchronous reset during WAIT drops the word
        grant(2'd1, 4'b0010, 1'b0, 8'h00);
        step();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_pop", 64'(pop), 64'd0);
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        v0 = valid_cnt;
        repeat (8) step();
        chk("rst_no_word", 64'(valid_cnt - v0), 64'd0);
        drain();

        // enb low for 3 cycles while in POP
        grant(2'd0, 4'b0001, 1'b1, 8'h11);
        enb = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("enb0_pop_cleared", 64'(pop), 64'd0);
        chk("enb0_no_valid", 64'(out_valid), 64'd0);
        step();
        step();
        enb = 1'b1;
        step();
        @(negedge clk);
        chk("resume_wait_valid", 64'(out_valid), 64'd0);
        step();
        @(negedge clk);
        chk("resume_hold_valid", 64'(out_valid), 64'd1);
        chk("resume_hold_data", 64'(out_data), 64'h11);
        drain();

        // Counter sequence 3,0,1,2,3 from a fresh reset
        rst = 1'b1;
        #3 rst = 1'b0;
        step();
        seq   = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        seq_d = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'hA5};
        for (int i = 0; i < 5; i++) begin
            grant(seq[i], 4'(4'b0001 << seq[i]), 1'b1, seq_d[i]);
            drain();
        end
`ifdef LECTOR_CONTADOR_EN
        exp_cnt = {16'd2, 16'd1, 16'd1, 16'd1};
`else
        exp_cnt = 64'd0;
`endif
        chk("contador", contador, exp_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
